vz_loader: RTL and testbench
============================

Name: vz_loader

Overview:
- Sits between the HPS file-download interface and the LASER310 system RAM write port.
- Parses a VZ snapshot streamed over ioctl: 24-byte header, then payload.
- Writes the payload into RAM at the start address given in the header.
- After the download ends, patches the ROM pointer cells so BASIC programs can RUN and machine code can be called via USR.

Parameters:
- VZ_INDEX, 8'd1, ioctl_index value that selects VZ downloads.
- CHECK_MAGIC, 1, 1 = reject files whose first 4 bytes are neither "VZF0" nor 20 20 00 00.
- BASIC_PTR_START, 16'h78A4, little-endian cell receiving the BASIC program start.
- BASIC_PTR_END, 16'h78F9, little-endian cell receiving the BASIC program end.
- USR_PTR, 16'h788E, little-endian cell receiving the machine-code entry.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download slot.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  16  byte offset within the file.
- ioctl_dout  in  8  byte value.
- mem_addr  out  16  RAM write address.
- mem_data  out  8  RAM write data.
- mem_wr  out  1  one-cycle RAM write strobe; RAM accepts every cycle.
- busy  out  1  high from download start until fixups complete.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag; cleared at the next VZ download start.
- file_type  out  8  header byte 21 (F0 = BASIC, F1 = machine code).
- start_addr  out  16  header bytes 22 (lo) and 23 (hi).
- end_addr  out  16  start_addr plus payload length, one past the last byte.

Behaviour:
- Reset: state IDLE, all outputs 0, payload count 0.
- Active download: dl = ioctl_download & (ioctl_index == VZ_INDEX).
- Edge detection: dl is registered; rising and falling edges are detected on clk_sys.
- Strobes are ignored when dl = 0.

States:
- IDLE: dl rise -> HDR. Clears err, file_type, start_addr, payload count; busy <= 1.
- HDR, on each ioctl_wr with ioctl_addr < 24:
  - bytes 0..3 go to the magic register;
  - byte 21 -> file_type;
  - byte 22 -> start_addr[7:0];
  - byte 23 -> start_addr[15:8];
  - bytes 4..20 (filename) are discarded.
  - On byte 23: if CHECK_MAGIC and magic is invalid -> ERR, else -> DATA.
- DATA, on ioctl_wr with ioctl_addr >= 24:
  - next cycle: mem_addr = start_addr + (ioctl_addr - 24), mod 2^16, wraps past FFFF;
  - mem_data = byte; mem_wr = 1 for exactly 1 cycle;
  - count = max(count, ioctl_addr - 23).
  - Write latency is exactly 1 cycle from ioctl_wr.
- dl fall in HDR (header shorter than 24 bytes) -> ERR. No RAM writes are issued.
- dl fall in DATA -> FIXUP; end_addr <= start_addr + count, mod 2^16.
- FIXUP issues writes on consecutive cycles, 1 byte per cycle:
  - file_type F0: BASIC_PTR_START <- start lo, +1 <- start hi, BASIC_PTR_END <- end lo, +1 <- end hi. 4 cycles.
  - file_type F1: USR_PTR <- start lo, +1 <- start hi. 2 cycles.
  - other types: no writes.
  - Then -> DONE.
- DONE: done = 1 for 1 cycle, busy <= 0 -> IDLE.
- ERR: err = 1, busy <= 0, mem_wr held 0. Remaining strobes are ignored. -> IDLE when dl = 0.
- A dl rise in any state aborts the current operation: remaining fixups are dropped and the block restarts at HDR with err cleared.
- Reset mid-download or mid-FIXUP forces IDLE with no further writes. A download still in progress after reset is ignored until its next dl rise.
- Zero-length payload: end_addr = start_addr. Fixups are still performed.
- ioctl_wr coincident with the dl fall is processed before entering FIXUP.

Test Plan:
- VZF0 BASIC file, start 7AE9, 5 payload bytes 11..15 -> writes at 7AE9..7AED with 1-cycle latency; then 78A4=E9, 78A5=7A, 78F9=EE, 78FA=7A on 4 consecutive cycles; done pulse; end_addr=7AEE.
- F1 file, start 8000, 3 bytes -> RAM 8000..8002 written; 788E=00, 788F=80; no BASIC pointer writes.
- Magic "ABCD" with CHECK_MAGIC=1 -> err=1, zero mem_wr, no done; the next valid download clears err.
- Download aborted after 10 bytes -> err=1, no mem_wr; F1 type, start FFFE, 4 bytes -> addresses FFFE, FFFF, 0000, 0001; end_addr=0002.
- ioctl_index=0 (ROM slot) stream -> no mem_wr, busy stays 0.
- Reset asserted during FIXUP after 2 writes -> no further writes, all outputs 0.
- New download starting during FIXUP -> remaining fixups dropped, HDR restarts.

Source files
------------

// File: rtl/vz_loader.sv
// ---------------------------------------------------------------------------
// vz_loader
//
// Takes a VZ snapshot streamed over the HPS ioctl download port and loads it
// into LASER310 RAM. The file has a 24-byte header followed by the payload.
// The payload lands at the start address from the header. After the stream
// ends, the ROM pointer cells are patched. A BASIC file (type F0) gets its
// program start/end pointers set so that RUN works. A machine-code file
// (type F1) gets the USR entry pointer set.
//
// Ports
//   clk_sys        system clock, all logic on the rising edge
//   reset          synchronous, active-high
//   ioctl_download download in progress
//   ioctl_index    download slot; only VZ_INDEX is acted on
//   ioctl_wr       one-cycle byte strobe
//   ioctl_addr     byte offset within the file
//   ioctl_dout     byte value
//   mem_addr       RAM write address
//   mem_data       RAM write data
//   mem_wr         one-cycle RAM write strobe
//   busy           high from download start until fixups complete
//   done           one-cycle pulse on successful completion
//   err            sticky error, cleared at the next VZ download start
//   file_type      header byte 21
//   start_addr     header bytes 22 (lo) / 23 (hi)
//   end_addr       start_addr + payload length (one past the last byte)
//
// Handshake: there is no back-pressure on either side. Each cycle with
// ioctl_wr high while the VZ download is active delivers exactly one byte.
// Each cycle with mem_wr high is exactly one RAM write, and the RAM accepts
// it in that same cycle. A payload byte reaches mem_* exactly one cycle after
// its ioctl_wr.
// ---------------------------------------------------------------------------
module vz_loader #(
  parameter logic [7:0]  VZ_INDEX        = 8'd1,
  parameter bit          CHECK_MAGIC     = 1'b1,
  parameter logic [15:0] BASIC_PTR_START = 16'h78A4,
  parameter logic [15:0] BASIC_PTR_END   = 16'h78F9,
  parameter logic [15:0] USR_PTR         = 16'h788E
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  file_type,
  output logic [15:0] start_addr,
  output logic [15:0] end_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t      state_q;
  logic        dl;
  logic        dl_q;
  logic        dl_rise;
  logic        dl_fall;
  logic        acc;
  logic        hdr_wr;
  logic        data_wr;
  logic [31:0] magic_q;
  logic        magic_ok;
  logic [15:0] count_q;
  logic [15:0] count_nxt;
  logic [15:0] cand;
  logic [15:0] off;
  logic [15:0] hdr_start;
  logic [1:0]  fix_idx_q;
  logic        fix_en;
  logic        fix_last;
  logic [15:0] fix_addr;
  logic [7:0]  fix_data;

  assign dl      = ioctl_download & (ioctl_index == VZ_INDEX);
  assign dl_rise = dl & ~dl_q;
  assign dl_fall = ~dl & dl_q;
  // A strobe in the same cycle as the falling edge still belongs to the file.
  assign acc     = ioctl_wr & (dl | dl_q);
  assign hdr_wr  = acc & (ioctl_addr < 16'd24);
  assign data_wr = acc & (ioctl_addr >= 16'd24);

  assign off       = ioctl_addr - 16'd24;
  assign cand      = ioctl_addr - 16'd23;
  assign count_nxt = (data_wr && (cand > count_q)) ? cand : count_q;
  // The start address as it will be once the header byte 23 now on the bus is stored.
  assign hdr_start = {ioctl_dout, start_addr[7:0]};

  // Magic bytes are stored little-endian: byte 0 is in bits [7:0].
  assign magic_ok = (magic_q == 32'h3046_5A56) ||  // "VZF0"
                    (magic_q == 32'h0000_2020);    // 20 20 00 00

  // Pointer-cell write for the current fixup step.
  always_comb begin
    fix_en   = 1'b0;
    fix_last = 1'b1;
    fix_addr = 16'h0000;
    fix_data = 8'h00;
    case (file_type)
      8'hF0: begin
        fix_en   = 1'b1;
        fix_last = (fix_idx_q == 2'd3);
        case (fix_idx_q)
          2'd0: begin fix_addr = BASIC_PTR_START;         fix_data = start_addr[7:0];  end
          2'd1: begin fix_addr = BASIC_PTR_START + 16'd1; fix_data = start_addr[15:8]; end
          2'd2: begin fix_addr = BASIC_PTR_END;           fix_data = end_addr[7:0];    end
          default: begin fix_addr = BASIC_PTR_END + 16'd1; fix_data = end_addr[15:8]; end
        endcase
      end
      8'hF1: begin
        fix_en   = 1'b1;
        fix_last = (fix_idx_q == 2'd1);
        if (fix_idx_q[0]) begin
          fix_addr = USR_PTR + 16'd1;
          fix_data = start_addr[15:8];
        end else begin
          fix_addr = USR_PTR;
          fix_data = start_addr[7:0];
        end
      end
      default: ;
    endcase
  end

  // dl_q is not reset. If a download is still running when reset is released,
  // it must not show up as a rising edge.
  always_ff @(posedge clk_sys) begin
    dl_q <= dl;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mem_addr   <= 16'h0000;
      mem_data   <= 8'h00;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      file_type  <= 8'h00;
      start_addr <= 16'h0000;
      end_addr   <= 16'h0000;
      magic_q    <= 32'h0;
      count_q    <= 16'h0000;
      fix_idx_q  <= 2'd0;
    end else begin
      mem_wr <= 1'b0;
      done   <= 1'b0;
      if (dl_rise) begin
        // A new VZ download wins over whatever was in progress.
        state_q    <= S_HDR;
        busy       <= 1'b1;
        err        <= 1'b0;
        file_type  <= 8'h00;
        start_addr <= 16'h0000;
        magic_q    <= 32'h0;
        count_q    <= 16'h0000;
        fix_idx_q  <= 2'd0;
      end else begin
        unique case (state_q)
          S_IDLE: ;
          S_HDR: begin
            if (hdr_wr) begin
              case (ioctl_addr[4:0])
                5'd0:  magic_q[7:0]     <= ioctl_dout;
                5'd1:  magic_q[15:8]    <= ioctl_dout;
                5'd2:  magic_q[23:16]   <= ioctl_dout;
                5'd3:  magic_q[31:24]   <= ioctl_dout;
                5'd21: file_type        <= ioctl_dout;
                5'd22: start_addr[7:0]  <= ioctl_dout;
                5'd23: start_addr[15:8] <= ioctl_dout;
                default: ;
              endcase
            end
            if (hdr_wr && (ioctl_addr[4:0] == 5'd23)) begin
              if (CHECK_MAGIC && !magic_ok) begin
                state_q <= S_ERR;
                err     <= 1'b1;
                busy    <= 1'b0;
              end else if (dl_fall) begin
                // The header ended on its last byte: zero-length payload.
                state_q   <= S_FIXUP;
                end_addr  <= hdr_start;
                fix_idx_q <= 2'd0;
              end else begin
                state_q <= S_DATA;
              end
            end else if (dl_fall) begin
              state_q <= S_ERR;
              err     <= 1'b1;
              busy    <= 1'b0;
            end
          end
          S_DATA: begin
            if (data_wr) begin
              mem_wr   <= 1'b1;
              mem_addr <= start_addr + off;
              mem_data <= ioctl_dout;
              count_q  <= count_nxt;
            end
            if (dl_fall) begin
              state_q   <= S_FIXUP;
              end_addr  <= start_addr + count_nxt;
              fix_idx_q <= 2'd0;
            end
          end
          S_FIXUP: begin
            if (fix_en) begin
              mem_wr   <= 1'b1;
              mem_addr <= fix_addr;
              mem_data <= fix_data;
            end
            if (fix_last) state_q <= S_DONE;
            fix_idx_q <= fix_idx_q + 2'd1;
          end
          S_DONE: begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end
          S_ERR: begin
            if (!dl) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vz_loader.sv
module tb_vz_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  file_type;
  logic [15:0] start_addr;
  logic [15:0] end_addr;

  vz_loader dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
    .busy(busy), .done(done), .err(err), .file_type(file_type),
    .start_addr(start_addr), .end_addr(end_addr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  int          exp_due_q[$];  // >=0: exact cycle; -(k+1): k-th pointer fixup
  logic [15:0] log_a[$];
  logic [7:0]  log_d[$];
  int  done_cnt = 0;
  int  done_base = 0;
  int  fix_seen = 0;
  int  last_fix_cyc = 0;
  bit  chk_idle_busy = 1'b0;

  // reference model of the file being sent and of the expected outputs
  logic [7:0]  file_b [0:63];
  bit          m_ok;
  logic        m_err;
  logic [7:0]  m_ft;
  logic [15:0] m_start;
  logic [15:0] m_end;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d, input int due);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
    exp_due_q.push_back(due);
  endtask

  // Output monitor: every RAM write must match the next expected write.
  always @(negedge clk_sys) begin
    logic [15:0] ea;
    logic [7:0]  ed;
    int          due;
    if (done) done_cnt++;
    if (chk_idle_busy) begin
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL busy_foreign_slot actual=%b required=0", busy);
      end
    end
    if (mem_wr === 1'b1) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_data);
      checks++;
      if (exp_addr_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%h:%h required=none", mem_addr, mem_data);
      end else begin
        ea  = exp_addr_q.pop_front();
        ed  = exp_data_q.pop_front();
        due = exp_due_q.pop_front();
        if (mem_addr !== ea || mem_data !== ed) begin
          failures++;
          $display("FAIL write_value actual=%h:%h required=%h:%h", mem_addr, mem_data, ea, ed);
        end
        if (due >= 0 && cyc != due) begin
          failures++;
          $display("FAIL write_latency actual=%0d required=%0d", cyc, due);
        end
        if (due < -1 && cyc != last_fix_cyc + 1) begin
          failures++;
          $display("FAIL fixup_gap actual=%0d required=%0d", cyc, last_fix_cyc + 1);
        end
        if (due < 0) begin
          last_fix_cyc = cyc;
          fix_seen++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic bit magic_valid();
    return (file_b[0] == "V" && file_b[1] == "Z" && file_b[2] == "F" && file_b[3] == "0") ||
           (file_b[0] == 8'h20 && file_b[1] == 8'h20 && file_b[2] == 8'h00 && file_b[3] == 8'h00);
  endfunction

  task automatic make_file(input logic [31:0] mg, input logic [7:0] ft, input logic [15:0] st,
                           input int plen, input bit seq, input logic [7:0] base);
    for (int i = 0; i < 64; i++) file_b[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) file_b[i] = mg[8*i +: 8];
    file_b[21] = ft;
    file_b[22] = st[7:0];
    file_b[23] = st[15:8];
    if (seq) for (int i = 0; i < plen; i++) file_b[24+i] = base + 8'(i);
  endtask

  task automatic stream(input logic [7:0] idx, input int len, input bit coinc, input int gap);
    bit sel;
    sel = (idx == 8'd1);
    done_base = done_cnt;
    if (sel) begin
      m_ft    = (len > 21) ? file_b[21] : 8'h00;
      m_start = {(len > 23) ? file_b[23] : 8'h00, (len > 22) ? file_b[22] : 8'h00};
      m_ok    = (len >= 24) && magic_valid();
      m_err   = !m_ok;
      if (m_ok) m_end = m_start + 16'(len - 24);
    end else begin
      m_ok = 1'b0;
      chk_idle_busy = 1'b1;
    end
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
    tick();
    for (int a = 0; a < len; a++) begin
      ioctl_addr = 16'(a);
      ioctl_dout = file_b[a];
      ioctl_wr = 1'b1;
      if (coinc && a == len - 1) ioctl_download = 1'b0;
      if (m_ok && a >= 24) push(m_start + 16'(a - 24), file_b[a], cyc + 1);
      tick();
      ioctl_wr = 1'b0;
      if (a != len - 1) repeat ($urandom_range(0, gap)) tick();
    end
  endtask

  task automatic push_fixups();
    if (m_ft == 8'hF0) begin
      push(16'h78A4, m_start[7:0], -1);
      push(16'h78A5, m_start[15:8], -2);
      push(16'h78F9, m_end[7:0], -3);
      push(16'h78FA, m_end[15:8], -4);
    end else if (m_ft == 8'hF1) begin
      push(16'h788E, m_start[7:0], -1);
      push(16'h788F, m_start[15:8], -2);
    end
  endtask

  task automatic finish_file();
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    if (m_ok) push_fixups();
    repeat (14) tick();
    chk_idle_busy = 1'b0;
    chk("pending_writes", exp_addr_q.size(), 0);
    chk("done_count", done_cnt - done_base, m_ok ? 1 : 0);
    chk("err", err, m_err);
    chk("file_type", file_type, m_ft);
    chk("start_addr", start_addr, m_start);
    chk("end_addr", end_addr, m_end);
    chk("busy_after", busy, 0);
  endtask

  task automatic wait_fix(input int n);
    int base;
    base = fix_seen;
    for (int i = 0; i < 40; i++) begin
      if (fix_seen - base >= n) break;
      @(negedge clk_sys);
      #1;
    end
    chk("wait_fixups", fix_seen - base, n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_data"}, mem_data, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_file_type"}, file_type, 0);
    chk({tag, "_start_addr"}, start_addr, 0);
    chk({tag, "_end_addr"}, end_addr, 0);
  endtask

  function automatic void clear_log();
    log_a.delete();
    log_d.delete();
  endfunction

  // ---------------- stimulus ----------------
  localparam logic [31:0] MG_VZF0 = 32'h3046_5A56;
  localparam logic [31:0] MG_SPC  = 32'h0000_2020;
  localparam logic [31:0] MG_BAD  = 32'h4443_4241;  // "ABCD"

  initial begin
    logic [31:0] mg;
    logic [7:0]  ft;
    logic [7:0]  idx;
    int          plen;
    int          len;
    int          r;

    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = 16'h0;
    ioctl_dout = 8'h0;
    m_err = 1'b0; m_ft = 8'h0; m_start = 16'h0; m_end = 16'h0; m_ok = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // BASIC file, start 7AE9, payload 11..15
    clear_log();
    make_file(MG_VZF0, 8'hF0, 16'h7AE9, 5, 1'b1, 8'h11);
    stream(8'd1, 29, 1'b0, 2);
    finish_file();
    chk("t1_log_size", log_a.size(), 9);
    chk("t1_first_addr", log_a[0], 16'h7AE9);
    chk("t1_first_data", log_d[0], 8'h11);
    chk("t1_last_addr", log_a[4], 16'h7AED);
    chk("t1_last_data", log_d[4], 8'h15);
    chk("t1_fix0", {log_a[5], log_d[5]}, 24'h78A4E9);
    chk("t1_fix1", {log_a[6], log_d[6]}, 24'h78A57A);
    chk("t1_fix2", {log_a[7], log_d[7]}, 24'h78F9EE);
    chk("t1_fix3", {log_a[8], log_d[8]}, 24'h78FA7A);
    chk("t1_end_addr", end_addr, 16'h7AEE);

    // machine-code file, start 8000, 3 bytes
    clear_log();
    make_file(MG_SPC, 8'hF1, 16'h8000, 3, 1'b0, 8'h00);
    stream(8'd1, 27, 1'b1, 1);
    finish_file();
    chk("t2_log_size", log_a.size(), 5);
    chk("t2_data2_addr", log_a[2], 16'h8002);
    chk("t2_fix0", {log_a[3], log_d[3]}, 24'h788E00);
    chk("t2_fix1", {log_a[4], log_d[4]}, 24'h788F80);

    // bad magic, then a valid file clears err
    clear_log();
    make_file(MG_BAD, 8'hF0, 16'h9000, 4, 1'b0, 8'h00);
    stream(8'd1, 28, 1'b0, 1);
    finish_file();
    chk("t3_err", err, 1);
    chk("t3_no_writes", log_a.size(), 0);
    make_file(MG_VZF0, 8'h55, 16'h5000, 2, 1'b0, 8'h00);
    stream(8'd1, 26, 1'b0, 1);
    finish_file();
    chk("t3_err_cleared", err, 0);

    // aborted after 10 bytes, then wrap-around load
    clear_log();
    make_file(MG_VZF0, 8'hF1, 16'h1111, 4, 1'b0, 8'h00);
    stream(8'd1, 10, 1'b0, 1);
    finish_file();
    chk("t4_err", err, 1);
    chk("t4_no_writes", log_a.size(), 0);
    make_file(MG_VZF0, 8'hF1, 16'hFFFE, 4, 1'b0, 8'h00);
    stream(8'd1, 28, 1'b0, 1);
    finish_file();
    chk("t4_wrap_addrs", {log_a[0], log_a[1], log_a[2], log_a[3]}, 64'hFFFE_FFFF_0000_0001);
    chk("t4_end_addr", end_addr, 16'h0002);

    // foreign slot is ignored
    clear_log();
    make_file(MG_VZF0, 8'hF0, 16'h3000, 4, 1'b0, 8'h00);
    stream(8'd0, 28, 1'b0, 1);
    finish_file();
    chk("t5_no_writes", log_a.size(), 0);

    // reset during fixup, after two pointer writes
    clear_log();
    make_file(MG_VZF0, 8'hF0, 16'h1234, 3, 1'b0, 8'h00);
    stream(8'd1, 27, 1'b0, 1);
    ioctl_download = 1'b0;
    push_fixups();
    wait_fix(2);
    reset = 1'b1;
    exp_addr_q.delete(); exp_data_q.delete(); exp_due_q.delete();
    tick();
    tick();
    chk_all_zero("midfix_reset");
    reset = 1'b0;
    m_err = 1'b0; m_ft = 8'h0; m_start = 16'h0; m_end = 16'h0;
    repeat (10) tick();
    chk("t6_log_size", log_a.size(), 5);

    // new download during fixup drops the rest
    clear_log();
    make_file(MG_VZF0, 8'hF0, 16'h6000, 2, 1'b0, 8'h00);
    stream(8'd1, 26, 1'b0, 1);
    ioctl_download = 1'b0;
    push_fixups();
    wait_fix(1);
    ioctl_download = 1'b1;
    exp_addr_q.delete(); exp_data_q.delete(); exp_due_q.delete();
    make_file(MG_VZF0, 8'hF1, 16'h4000, 2, 1'b0, 8'h00);
    stream(8'd1, 26, 1'b0, 1);
    finish_file();
    chk("t7_log_size", log_a.size(), 7);
    chk("t7_single_fix", log_a[2], 16'h78A4);

    // randomized files
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      mg = (r == 0) ? MG_BAD : ((r < 5) ? MG_VZF0 : MG_SPC);
      r = $urandom_range(0, 3);
      ft = (r < 2) ? 8'hF0 : ((r == 2) ? 8'hF1 : 8'($urandom));
      plen = (i == 0) ? 0 : $urandom_range(0, 16);
      make_file(mg, ft, 16'($urandom), plen, 1'b0, 8'h00);
      len = 24 + plen;
      if ($urandom_range(0, 7) == 0) len = $urandom_range(1, 23);
      idx = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'd1;
      stream(idx, len, 1'($urandom_range(0, 1)), 2);
      finish_file();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
